// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM auto-refresh slice: command encodings,
// address-bus constants and the refresh sequencer state type.
package sdram_pkg;

    // SDRAM commands as {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0]  CMD_NOP          = 4'b0111;
    localparam logic [3:0]  CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0]  CMD_AUTO_REFRESH = 4'b0001;

    // Address / bank values driven by the refresh block
    localparam logic [11:0] ADDR_IDLE    = 12'hFFF;
    localparam logic [11:0] ADDR_PRE_ALL = 12'h400;   // A10=1 selects all banks
    localparam logic [11:0] ADDR_ZERO    = 12'h000;
    localparam logic [1:0]  BA_IDLE      = 2'b11;
    localparam logic [1:0]  BA_ZERO      = 2'b00;

    // Refresh sequencer states
    typedef enum logic [2:0] {
        AR_IDLE     = 3'd0,
        AR_PRE      = 3'd1,
        AR_WAIT_RP  = 3'd2,
        AR_AREF     = 3'd3,
        AR_WAIT_RFC = 3'd4,
        AR_DONE     = 3'd5
    } ar_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer with a sticky pending-request flag.
// Optional build macro SDRAM_AR_URGENT_EN adds a sticky "interval missed" flag.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 750
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic init_done_i,
    input  logic accept_i,
    output logic req_o
`ifdef SDRAM_AR_URGENT_EN
    ,
    output logic urgent_o
`endif
);

    localparam int unsigned TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TW-1:0] TC = TW'(REF_INTERVAL - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          expire_s;
    logic          req_q, req_d;

    // Next timer value and expiry strobe; the timer free-runs while init_done is high
    always_comb begin
        timer_d  = timer_q;
        expire_s = 1'b0;
        if (!init_done_i) begin
            timer_d = '0;
        end else if (timer_q == TC) begin
            timer_d  = '0;
            expire_s = 1'b1;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Pending request: expiry sets (and wins over accept), accept clears
    always_comb begin
        req_d = req_q;
        if (!init_done_i) begin
            req_d = 1'b0;
        end else if (expire_s) begin
            req_d = 1'b1;
        end else if (accept_i) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q;
        end
    end

    // Timer and request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
            req_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            req_q   <= req_d;
        end
    end

    assign req_o = req_q;

`ifdef SDRAM_AR_URGENT_EN
    logic urgent_q, urgent_d;

    // Urgent flag: an expiry found a request still pending; set wins over accept
    always_comb begin
        urgent_d = urgent_q;
        if (expire_s && req_q) begin
            urgent_d = 1'b1;
        end else if (accept_i) begin
            urgent_d = 1'b0;
        end else begin
            urgent_d = urgent_q;
        end
    end

    // Urgent flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            urgent_q <= 1'b0;
        end else begin
            urgent_q <= urgent_d;
        end
    end

    assign urgent_o = urgent_q;
`endif

endmodule

// File: rtl/sdram_auto_refresh.sv
// SDRAM auto-refresh block: periodic request generation plus the
// PRECHARGE ALL / AUTO REFRESH command sequence on the ar_* bus.
// Optional build macro SDRAM_AR_URGENT_EN adds the ar_urgent output.
module sdram_auto_refresh
    import sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 750,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned AR_COUNT     = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic        ar_en,
    output logic        ar_req,
    output logic        ar_end,
    output logic [11:0] ar_addro,
    output logic [1:0]  ar_bao,
    output logic [3:0]  ar_cmdo
`ifdef SDRAM_AR_URGENT_EN
    ,
    output logic        ar_urgent
`endif
);

    localparam int unsigned WMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int unsigned WW   = $clog2(WMAX + 1);
    localparam int unsigned RW   = $clog2(AR_COUNT + 1);
    // Last wait-counter value in each wait state (waits last T-1 cycles)
    localparam logic [WW-1:0] RP_LAST  = (T_RP  >= 2) ? WW'(T_RP  - 2) : '0;
    localparam logic [WW-1:0] RFC_LAST = (T_RFC >= 2) ? WW'(T_RFC - 2) : '0;
    localparam logic [RW-1:0] REF_MAX  = RW'(AR_COUNT);

    ar_state_e     state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          accept_s;
    logic [3:0]    cmd_q, cmd_d;
    logic [11:0]   addr_q, addr_d;
    logic [1:0]    ba_q, ba_d;
    logic          end_q, end_d;

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_timer (
        .clk_i       (sys_clk),
        .rst_ni      (sys_rst_n),
        .init_done_i (init_done),
        .accept_i    (accept_s),
        .req_o       (ar_req)
`ifdef SDRAM_AR_URGENT_EN
        ,
        .urgent_o    (ar_urgent)
`endif
    );

    // Sequencer next state; ar_en only matters in IDLE
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        ref_d    = ref_q;
        accept_s = 1'b0;
        case (state_q)
            AR_IDLE: begin
                if (ar_en) begin
                    accept_s = 1'b1;
                    ref_d    = '0;
                    state_d  = AR_PRE;
                end else begin
                    state_d  = AR_IDLE;
                end
            end
            AR_PRE: begin
                wait_d = '0;
                if (T_RP <= 1) begin
                    state_d = AR_AREF;
                end else begin
                    state_d = AR_WAIT_RP;
                end
            end
            AR_WAIT_RP: begin
                if (wait_q == RP_LAST) begin
                    state_d = AR_AREF;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            AR_AREF: begin
                ref_d   = ref_q + RW'(1);
                wait_d  = '0;
                state_d = AR_WAIT_RFC;
            end
            AR_WAIT_RFC: begin
                if (wait_q == RFC_LAST) begin
                    if (ref_q < REF_MAX) begin
                        state_d = AR_AREF;
                    end else begin
                        state_d = AR_DONE;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            AR_DONE: begin
                state_d = AR_IDLE;
            end
            default: begin
                state_d = AR_IDLE;
            end
        endcase
    end

    // Bus values for the state being entered, so outputs are registered with it
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = ADDR_IDLE;
        ba_d   = BA_IDLE;
        end_d  = 1'b0;
        case (state_d)
            AR_PRE: begin
                cmd_d  = CMD_PRECHARGE;
                addr_d = ADDR_PRE_ALL;
                ba_d   = BA_ZERO;
            end
            AR_AREF: begin
                cmd_d  = CMD_AUTO_REFRESH;
                addr_d = ADDR_ZERO;
                ba_d   = BA_ZERO;
            end
            AR_DONE: begin
                end_d = 1'b1;
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    // Sequencer state, counters and registered command bus
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= AR_IDLE;
            wait_q  <= '0;
            ref_q   <= '0;
            cmd_q   <= CMD_NOP;
            addr_q  <= ADDR_IDLE;
            ba_q    <= BA_IDLE;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ref_q   <= ref_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            end_q   <= end_d;
        end
    end

    assign ar_cmdo  = cmd_q;
    assign ar_addro = addr_q;
    assign ar_bao   = ba_q;
    assign ar_end   = end_q;

endmodule
